// File: rtl/gates_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gates_monitor: checks observed AND/OR/NOT/NAND outputs against iA/iB.       |
// | Optional first-failure capture: define GATES_MONITOR_FAILCAP_EN.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module gates_monitor (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic       iStart,
    input  logic       iValid,
    input  logic       iA,
    input  logic       iB,
    input  logic       iAND,
    input  logic       iOR,
    input  logic       iNOT,
    input  logic       iNAND,
    input  logic       iNAND2,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [3:0] oErrCnt,
    output logic [3:0] oSeen
`ifdef GATES_MONITOR_FAILCAP_EN
    ,
    output logic [6:0] oFailVec,
    output logic       oFailVld
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_ERR_MAX  = 4'hF;
    localparam logic [3:0] C_SEEN_ALL = 4'hF;

    state_t     state_q, state_d;
    logic [3:0] err_q, err_d;
    logic [3:0] seen_q, seen_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [4:0] w_expected;
    logic [4:0] w_observed;
    logic       w_mismatch;
    logic [3:0] w_seen_bit;
    logic       w_check;

    assign w_expected = {iA & iB, iA | iB, ~iA, ~(iA & iB), ~(iA & iB)};
    assign w_observed = {iAND, iOR, iNOT, iNAND, iNAND2};
    // Any number of differing bits counts as one mismatching vector.
    assign w_mismatch = |(w_expected ^ w_observed);
    assign w_seen_bit = 4'b0001 << {iA, iB};
    // A simultaneous start discards the sample.
    assign w_check    = (state_q == S_RUN) && iValid && !iStart;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        seen_d  = seen_q;
        if (iStart) begin
            state_d = S_RUN;
            err_d   = 4'd0;
            seen_d  = 4'd0;
        end else if (w_check) begin
            if (w_mismatch && (err_q != C_ERR_MAX)) begin
                err_d = err_q + 4'd1;
            end
            seen_d = seen_q | w_seen_bit;
            if (seen_d == C_SEEN_ALL) begin
                state_d = S_DONE;
            end
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == 4'd0);
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q <= S_IDLE;
            err_q   <= 4'd0;
            seen_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oPass   = pass_q;
    assign oErrCnt = err_q;
    assign oSeen   = seen_q;

`ifdef GATES_MONITOR_FAILCAP_EN
    logic [6:0] fvec_q, fvec_d;
    logic       fvld_q, fvld_d;

    // Only the first mismatch of a run is kept.
    always_comb begin
        fvec_d = fvec_q;
        fvld_d = fvld_q;
        if (iStart) begin
            fvec_d = 7'd0;
            fvld_d = 1'b0;
        end else if (w_check && w_mismatch && !fvld_q) begin
            fvec_d = {iA, iB, w_observed};
            fvld_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            fvec_q <= 7'd0;
            fvld_q <= 1'b0;
        end else begin
            fvec_q <= fvec_d;
            fvld_q <= fvld_d;
        end
    end

    assign oFailVec = fvec_q;
    assign oFailVld = fvld_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gates_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gates_monitor: directed scoreboard bench for gates_monitor.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_gates_monitor;

    logic       iCLK = 1'b0;
    logic       iRSTn = 1'b0;
    logic       iStart = 1'b0;
    logic       iValid = 1'b0;
    logic       iA = 1'b0;
    logic       iB = 1'b0;
    logic       iAND = 1'b0;
    logic       iOR = 1'b0;
    logic       iNOT = 1'b0;
    logic       iNAND = 1'b0;
    logic       iNAND2 = 1'b0;
    logic       oBusy;
    logic       oDone;
    logic       oPass;
    logic [3:0] oErrCnt;
    logic [3:0] oSeen;
`ifdef GATES_MONITOR_FAILCAP_EN
    logic [6:0] oFailVec;
    logic       oFailVld;
`endif

    gates_monitor dut (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .iStart  (iStart),
        .iValid  (iValid),
        .iA      (iA),
        .iB      (iB),
        .iAND    (iAND),
        .iOR     (iOR),
        .iNOT    (iNOT),
        .iNAND   (iNAND),
        .iNAND2  (iNAND2),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oPass   (oPass),
        .oErrCnt (oErrCnt),
        .oSeen   (oSeen)
`ifdef GATES_MONITOR_FAILCAP_EN
        ,
        .oFailVec(oFailVec),
        .oFailVld(oFailVld)
`endif
    );

    always #5 iCLK = ~iCLK;

    // Packed expectation: {busy, done, pass, errcnt[3:0], seen[3:0]}.
    typedef struct {
        logic [10:0] exp;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    // flip bits (order AND,OR,NOT,NAND,NAND2) inject wrong gate outputs.
    task automatic step(input logic rstn, input logic start, input logic valid,
                        input logic a, input logic b, input logic [4:0] flip,
                        input logic busy, input logic done, input logic pass,
                        input logic [3:0] err, input logic [3:0] seen, input string tag);
        sb_t e;
        sb_t got;
        logic [4:0] good;
        logic [10:0] obs;
        good = {a & b, a | b, ~a, ~(a & b), ~(a & b)} ^ flip;
        iRSTn  = rstn;
        iStart = start;
        iValid = valid;
        iA     = a;
        iB     = b;
        {iAND, iOR, iNOT, iNAND, iNAND2} = good;
        e.exp = {busy, done, pass, err, seen};
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge iCLK);
        #1;
        got = sb_q.pop_front();
        obs = {oBusy, oDone, oPass, oErrCnt, oSeen};
        checks++;
        assert (obs === got.exp) else begin
            errors++;
            $error("FAIL %s: observed {busy,done,pass,err,seen}=%b expected %b", got.tag, obs, got.exp);
        end
        iStart = 1'b0;
        iValid = 1'b0;
    endtask

    initial begin
        // Reset state, with junk inputs that must be overridden.
        step(0, 1, 1, 0, 0, 5'b10000, 0, 0, 0, 4'd0, 4'h0, "reset_a");
        step(0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 4'd0, 4'h0, "reset_b");
        step(1, 0, 1, 1, 1, 5'b00000, 0, 0, 0, 4'd0, 4'h0, "idle_valid_ignored");

        // All-correct run.
        step(1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h0, "p1_start");
        step(1, 0, 1, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h1, "p1_v00");
        step(1, 0, 1, 0, 1, 5'b00000, 1, 0, 0, 4'd0, 4'h3, "p1_v01");
        step(1, 0, 1, 1, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h7, "p1_v10");
        step(1, 0, 1, 1, 1, 5'b00000, 0, 1, 1, 4'd0, 4'hF, "p1_v11_done");
        step(1, 0, 1, 0, 0, 5'b11111, 0, 1, 1, 4'd0, 4'hF, "p1_done_hold");

        // Single OR fault on vector 01; restart directly from DONE.
        step(1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h0, "p2_restart");
        step(1, 0, 1, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h1, "p2_v00");
        step(1, 0, 1, 0, 1, 5'b01000, 1, 0, 0, 4'd1, 4'h3, "p2_v01_bad");
        step(1, 0, 1, 1, 0, 5'b00000, 1, 0, 0, 4'd1, 4'h7, "p2_v10");
        step(1, 0, 1, 1, 1, 5'b00000, 0, 1, 0, 4'd1, 4'hF, "p2_v11_done");
`ifdef GATES_MONITOR_FAILCAP_EN
        checks++;
        assert ({oFailVld, oFailVec} === {1'b1, 7'b0100111}) else begin
            errors++;
            $error("FAIL p2_failcap: observed vld/vec=%b/%b expected 1/0100111", oFailVld, oFailVec);
        end
`endif

        // Saturation: 20 bad 00 vectors with all output bits wrong on some.
        step(1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h0, "p3_start");
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 0, 0, (i % 2 == 0) ? 5'b10000 : 5'b11111,
                 1, 0, 0, (i >= 14) ? 4'd15 : 4'(i + 1), 4'h1, "p3_bad00");
        end
        step(1, 0, 1, 0, 1, 5'b00000, 1, 0, 0, 4'd15, 4'h3, "p3_v01");
        step(1, 0, 1, 1, 0, 5'b00000, 1, 0, 0, 4'd15, 4'h7, "p3_v10");
        step(1, 0, 1, 1, 1, 5'b00010, 0, 1, 0, 4'd15, 4'hF, "p3_v11_done");

        // Mid-run reset, then valid without start.
        step(1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h0, "p4_start");
        step(1, 0, 1, 0, 0, 5'b00001, 1, 0, 0, 4'd1, 4'h1, "p4_v00_bad");
        step(1, 0, 1, 0, 1, 5'b00000, 1, 0, 0, 4'd1, 4'h3, "p4_v01");
        step(1, 0, 1, 1, 0, 5'b00000, 1, 0, 0, 4'd1, 4'h7, "p4_v10");
        step(0, 0, 1, 1, 1, 5'b00000, 0, 0, 0, 4'd0, 4'h0, "p4_reset");
        step(1, 0, 1, 1, 1, 5'b00000, 0, 0, 0, 4'd0, 4'h0, "p4_post_reset_valid");
`ifdef GATES_MONITOR_FAILCAP_EN
        checks++;
        assert ({oFailVld, oFailVec} === 8'd0) else begin
            errors++;
            $error("FAIL p4_failcap_reset: observed vld/vec=%b/%b expected 0/0000000", oFailVld, oFailVec);
        end
`endif

        // Start and valid together: start wins, sample dropped.
        step(1, 1, 0, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h0, "p5_start");
        step(1, 0, 1, 0, 0, 5'b00000, 1, 0, 0, 4'd0, 4'h1, "p5_v00");
        step(1, 0, 1, 0, 1, 5'b00100, 1, 0, 0, 4'd1, 4'h3, "p5_v01_bad");
        step(1, 0, 1, 1, 0, 5'b00000, 1, 0, 0, 4'd1, 4'h7, "p5_v10");
        step(1, 1, 1, 1, 1, 5'b00000, 1, 0, 0, 4'd0, 4'h0, "p5_start_wins");
`ifdef GATES_MONITOR_FAILCAP_EN
        checks++;
        assert ({oFailVld, oFailVec} === 8'd0) else begin
            errors++;
            $error("FAIL p5_failcap_clear: observed vld/vec=%b/%b expected 0/0000000", oFailVld, oFailVec);
        end
`endif
        step(1, 0, 1, 1, 1, 5'b00000, 1, 0, 0, 4'd0, 4'h8, "p5_v11_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
